// File: rtl/axil_pkg.sv
// Shared response codes and read-channel state type for the AXI-Lite register slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage: one byte-enabled write port, one combinational read port,
// and the flat contents output.
module axil_reg_bank #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic [IDX_W-1:0]               raddr_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        mem_q[k] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave with word-indexed addressing, independent AW/W capture,
// SLVERR for out-of-range accesses and a per-register write strobe.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic                    rst_done_q;
  logic                    aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic [NUM_REGS-1:0]     wr_pulse_q;
  rstate_e                 rstate_q;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;

  logic                    aw_ready, w_ready, ar_ready;
  logic                    aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_ok, rd_ok, bank_we;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   bank_rdata;

  // rst_done_q keeps every ready low while reset is held and until the first edge after it.
  assign aw_ready = rst_done_q && !aw_held_q && !bvalid_q;
  assign w_ready  = rst_done_q && !w_held_q && !bvalid_q;
  assign ar_ready = rst_done_q && (rstate_q == R_IDLE);

  assign aw_fire = AWVALID && aw_ready;
  assign w_fire  = WVALID && w_ready;
  assign ar_fire = ARVALID && ar_ready;

  assign wr_addr = aw_held_q ? awaddr_q : AWADDR;
  assign wr_data = w_held_q ? wdata_q : WDATA;
  assign wr_strb = w_held_q ? wstrb_q : WSTRB;
  assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire) && !bvalid_q;

  assign wr_ok   = {1'b0, wr_addr} < LIMIT;
  assign rd_ok   = {1'b0, ARADDR} < LIMIT;
  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign rd_idx  = ARADDR[IDX_W-1:0];
  assign bank_we = commit && wr_ok;

  axil_reg_bank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .we_i    (bank_we),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .raddr_i (rd_idx),
    .rdata_o (bank_rdata),
    .regs_o  (regs_o)
  );

  // Held beats stay set through the response phase so the readies stay low until B completes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rst_done_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      rst_done_q <= 1'b1;
      wr_pulse_q <= '0;
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= AWADDR;
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        wdata_q  <= WDATA;
        wstrb_q  <= WSTRB;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          wr_pulse_q[wr_idx] <= 1'b1;
        end
      end else if (bvalid_q && BREADY) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_fire) begin
            rstate_q <= R_DATA;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? bank_rdata : '0;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: begin
          rstate_q <= R_IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign AWREADY    = aw_ready;
  assign WREADY     = w_ready;
  assign ARREADY    = ar_ready;
  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign RVALID     = rvalid_q;
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_axil_reg_slave;

  localparam int NR = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [31:0]   AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [31:0]   WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [31:0]   ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0] wr_pulse_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [NR];
  int pulse_cnt [NR];

  axil_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    for (int k = 0; k < NR; k++) pulse_cnt[k] = 0;
  end

  always @(posedge ACLK) begin
    for (int k = 0; k < NR; k++) if (wr_pulse_o[k]) pulse_cnt[k]++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void model_clear();
    for (int k = 0; k < NR; k++) model[k] = '0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    if (addr < NR)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr][8*b +: 8] = data[8*b +: 8];
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  function automatic int pulse_total();
    int s = 0;
    for (int k = 0; k < NR; k++) s += pulse_cnt[k];
    return s;
  endfunction

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    model_clear();
    @(negedge ACLK);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int cyc;
    bit aw_d, w_d, af, wf;
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    aw_d = 0; w_d = 0; cyc = 0;
    while (!(aw_d && w_d) && cyc < 50) begin
      af = AWVALID && AWREADY;
      wf = WVALID && WREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (af) begin AWVALID = 1'b0; aw_d = 1; end
      if (wf) begin WVALID = 1'b0; w_d = 1; end
      cyc++;
    end
    while (!BVALID && cyc < 50) begin @(negedge ACLK); cyc++; end
    resp = BRESP;
    if (cyc >= 50) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%0d: no B response within 50 cycles", addr);
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int cyc;
    bit ar_d, af;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    ar_d = 0; cyc = 0;
    while (!ar_d && cyc < 50) begin
      af = ARVALID && ARREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (af) begin ARVALID = 1'b0; ar_d = 1; end
      cyc++;
    end
    while (!RVALID && cyc < 50) begin @(negedge ACLK); cyc++; end
    data = RDATA; resp = RRESP;
    if (cyc >= 50) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%0d: no R response within 50 cycles", addr);
      ARVALID = 1'b0;
    end
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if ({BRESP, RRESP, RDATA, wr_pulse_o} !== '0 || regs_o !== '0) begin
      failures++;
      $display("FAIL reset_values: bresp=%b rresp=%b rdata=%h pulse=%h", BRESP, RRESP, RDATA, wr_pulse_o);
    end
    ARESET = 1'b0;
    model_clear();
    #1;
    checks++;
    if (AWREADY !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: AWREADY=%b want 0", AWREADY);
    end
    @(posedge ACLK); #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_edge: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int p0;
    p0 = pulse_cnt[0];
    axi_write(0, 32'h0398AA44, 4'hF, r);
    model_write(0, 32'h0398AA44, 4'hF);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL basic_bresp: got %b want 00", r); end
    repeat (2) @(negedge ACLK);
    checks++;
    if (pulse_cnt[0] - p0 != 1) begin
      failures++; $display("FAIL basic_pulse: got %0d cycles want 1", pulse_cnt[0] - p0);
    end
    axi_read(0, d, r);
    checks++;
    if (d !== model[0] || r !== 2'b00) begin
      failures++; $display("FAIL basic_read: got %h/%b want %h/00", d, r, model[0]);
    end
    checks++;
    if (regs_o !== model_flat()) begin failures++; $display("FAIL basic_regs: regs_o differs from model"); end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d;
    axi_write(1, 32'h00450008, 4'hF, r);
    model_write(1, 32'h00450008, 4'hF);
    axi_write(1, 32'hFFFFFFFF, 4'b0101, r);
    model_write(1, 32'hFFFFFFFF, 4'b0101);
    axi_read(1, d, r);
    checks++;
    if (d !== model[1] || r !== 2'b00) begin
      failures++; $display("FAIL strobe_read: got %h/%b want %h/00", d, r, model[1]);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d; bit wf;
    @(negedge ACLK);
    AWADDR = 2; WDATA = 32'h06400040; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wf = WVALID && WREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (wf) WVALID = 1'b0;
      checks++;
      if (BVALID !== 1'b0) begin failures++; $display("FAIL early_bvalid cyc%0d: got %b want 0", i, BVALID); end
    end
    WVALID = 1'b0;
    AWVALID = 1'b1;
    checks++;
    if (AWREADY !== 1'b1) begin failures++; $display("FAIL late_awready: got %b want 1", AWREADY); end
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    model_write(2, 32'h06400040, 4'hF);
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      failures++; $display("FAIL late_bvalid: got %b/%b want 1/00", BVALID, BRESP);
    end
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
    axi_read(2, d, r);
    checks++;
    if (d !== model[2]) begin failures++; $display("FAIL late_read: got %h want %h", d, model[2]); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; logic [NR*32-1:0] snap; int p;
    snap = regs_o; p = pulse_total();
    axi_write(20, $urandom, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL oor_bresp: got %b want 10", r); end
    axi_read(20, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL oor_read: got %h/%b want 0/10", d, r); end
    checks++;
    if (regs_o !== snap || pulse_total() != p) begin
      failures++; $display("FAIL oor_side_effect: regs or pulses changed (pulses %0d vs %0d)", pulse_total(), p);
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] r; logic [31:0] d, v;
    v = $urandom;
    @(negedge ACLK);
    AWADDR = 3; WDATA = v; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(3, v, 4'hF);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
        failures++; $display("FAIL stall_hold cyc%0d: got %b want 10000", i, {BVALID, BRESP, AWREADY, WREADY});
      end
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
    checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      failures++; $display("FAIL stall_release: got %b want 011", {BVALID, AWREADY, WREADY});
    end
    axi_read(3, d, r);
    checks++;
    if (d !== model[3]) begin failures++; $display("FAIL stall_read: got %h want %h", d, model[3]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [31:0] d, oldv, newv;
    oldv = $urandom; newv = ~oldv;
    axi_write(6, oldv, 4'hF, r);
    model_write(6, oldv, 4'hF);
    @(negedge ACLK);
    AWADDR = 6; WDATA = newv; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 6; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++; $display("FAIL b2b_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== model[6] || BVALID !== 1'b1) begin
      failures++; $display("FAIL b2b_prewrite: rvalid=%b rdata=%h bvalid=%b want 1/%h/1", RVALID, RDATA, BVALID, model[6]);
    end
    model_write(6, newv, 4'hF);
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    axi_read(6, d, r);
    checks++;
    if (d !== model[6]) begin failures++; $display("FAIL b2b_postwrite: got %h want %h", d, model[6]); end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] a, d, v; logic [3:0] s; int p;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, NR + 3);
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; s = 4'($urandom);
        p = (a < NR) ? pulse_cnt[a] : 0;
        axi_write(a, v, s, r);
        model_write(a, v, s);
        er = (a < NR) ? 2'b00 : 2'b10;
        @(negedge ACLK);
        checks++;
        if (r !== er || regs_o !== model_flat()) begin
          failures++; $display("FAIL rand_write%0d addr=%0d strb=%b: bresp %b want %b or regs differ", i, a, s, r, er);
        end
        if (a < NR) begin
          checks++;
          if (pulse_cnt[a] - p != 1) begin
            failures++; $display("FAIL rand_pulse%0d addr=%0d: got %0d want 1", i, a, pulse_cnt[a] - p);
          end
        end
      end else begin
        axi_read(a, d, r);
        checks++;
        if (a < NR) begin
          if (d !== model[a] || r !== 2'b00) begin
            failures++; $display("FAIL rand_read%0d addr=%0d: got %h/%b want %h/00", i, a, d, r, model[a]);
          end
        end else if (d !== 32'h0 || r !== 2'b10) begin
          failures++; $display("FAIL rand_read%0d addr=%0d: got %h/%b want 0/10", i, a, d, r);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int p;
    @(negedge ACLK);
    AWADDR = 5; AWVALID = 1'b1; WVALID = 1'b0; BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    #2 ARESET = 1'b1;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0 ||
        RDATA !== '0 || wr_pulse_o !== '0 || regs_o !== '0) begin
      failures++; $display("FAIL midreset_outputs: flags %b regs nonzero=%b",
                           {AWREADY, WREADY, ARREADY, BVALID, RVALID}, |regs_o);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    model_clear();
    p = pulse_total();
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      checks++;
      if (BVALID !== 1'b0) begin failures++; $display("FAIL midreset_no_commit cyc%0d: BVALID=%b want 0", i, BVALID); end
    end
    checks++;
    if (regs_o[5*32 +: 32] !== 32'h0 || pulse_total() != p) begin
      failures++; $display("FAIL midreset_reg5: got %h want 0", regs_o[5*32 +: 32]);
    end
    WVALID = 1'b0; BREADY = 1'b0;
    do_reset();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_out_of_range();
    test_bready_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_basic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
